// File: rtl/ysyx_23060240_clint.sv
// ysyx_23060240_clint: core-local interruptor on the saxi slave bus.
// Holds a free-running 64-bit mtime, a 64-bit mtimecmp and a registered
// machine-timer interrupt mtip. Reads and writes use independent channels
// with a one-cycle response.
// Optional build macro CLINT_RAND_DELAY_EN: adds 0..3 extra response cycles
// per transaction, drawn from an 8-bit LFSR, to exercise master tolerance of
// variable slave latency. Without it the response latency is fixed at 1.
module ysyx_23060240_clint #(
  parameter int TICK_DIV = 1,
  parameter int ADDR_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] clint_araddr,
  input  logic        clint_arvalid,
  output logic        clint_arready,
  output logic [31:0] clint_rdata,
  output logic        clint_rvalid,
  input  logic        clint_rready,
  input  logic [31:0] clint_awaddr,
  input  logic        clint_awvalid,
  output logic        clint_awready,
  input  logic [31:0] clint_wdata,
  input  logic        clint_wvalid,
  output logic        clint_wready,
  output logic        clint_bvalid,
  input  logic        clint_bready,
  output logic        mtip
);

  localparam logic [ADDR_W-1:0] OFF_CMP_LO   = ADDR_W'(16'h4000);
  localparam logic [ADDR_W-1:0] OFF_CMP_HI   = ADDR_W'(16'h4004);
  localparam logic [ADDR_W-1:0] OFF_MTIME_LO = ADDR_W'(16'hBFF8);
  localparam logic [ADDR_W-1:0] OFF_MTIME_HI = ADDR_W'(16'hBFFC);
  localparam logic [15:0]       TICK_LAST    = 16'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    R_IDLE,
    R_RESP
`ifdef CLINT_RAND_DELAY_EN
    , R_WAIT
`endif
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_RESP
`ifdef CLINT_RAND_DELAY_EN
    , W_WAIT
`endif
  } w_state_t;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [15:0] presc;
  logic        tick;
  logic [31:0] rdata_p1;
  logic        mtip_p1;
  logic        ar_hs;
  logic        w_hs;
  logic [ADDR_W-1:0] waddr;

  // Upper address bits are already decoded by the crossbar.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{clint_araddr[31:ADDR_W], clint_awaddr[31:ADDR_W]};

  // Register value seen by a read; unmapped offsets read as zero.
  function automatic logic [31:0] rd_mux(input logic [ADDR_W-1:0] a);
    logic [31:0] d;
    d = 32'h0;
    if (a == OFF_CMP_LO)        d = mtimecmp[31:0];
    else if (a == OFF_CMP_HI)   d = mtimecmp[63:32];
    else if (a == OFF_MTIME_LO) d = mtime[31:0];
    else if (a == OFF_MTIME_HI) d = mtime[63:32];
    return d;
  endfunction

  assign tick          = (presc == TICK_LAST);
  assign waddr         = clint_awaddr[ADDR_W-1:0];
  assign clint_arready = (r_state == R_IDLE);
  assign ar_hs         = clint_arvalid && clint_arready;
  assign w_hs          = (w_state == W_IDLE) && clint_awvalid && clint_wvalid;
  assign clint_awready = w_hs;
  assign clint_wready  = w_hs;
  assign clint_rvalid  = (r_state == R_RESP);
  assign clint_bvalid  = (w_state == W_RESP);
  assign clint_rdata   = rdata_p1;
  assign mtip          = mtip_p1;

`ifdef CLINT_RAND_DELAY_EN
  logic [7:0] lfsr;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt;

  // Maximal-length LFSR x^8+x^6+x^5+x^4+1, stepping every cycle.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Extra-delay down-counters, loaded at each handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 2'd0;
      w_cnt <= 2'd0;
    end else begin
      if (ar_hs)                 r_cnt <= lfsr[1:0];
      else if (r_state == R_WAIT) r_cnt <= r_cnt - 2'd1;
      if (w_hs)                  w_cnt <= lfsr[1:0];
      else if (w_state == W_WAIT) w_cnt <= w_cnt - 2'd1;
    end
  end
`endif

  // Prescaler: one mtime tick every TICK_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst)       presc <= 16'd0;
    else if (tick) presc <= 16'd0;
    else           presc <= presc + 16'd1;
  end

  // mtime: a bus write to either half beats a same-cycle tick.
  always_ff @(posedge clk) begin
    if (rst)                              mtime <= 64'd0;
    else if (w_hs && waddr == OFF_MTIME_LO) mtime[31:0] <= clint_wdata;
    else if (w_hs && waddr == OFF_MTIME_HI) mtime[63:32] <= clint_wdata;
    else if (tick)                        mtime <= mtime + 64'd1;
  end

  // mtimecmp: software-written compare value.
  always_ff @(posedge clk) begin
    if (rst)                            mtimecmp <= '1;
    else if (w_hs && waddr == OFF_CMP_LO) mtimecmp[31:0] <= clint_wdata;
    else if (w_hs && waddr == OFF_CMP_HI) mtimecmp[63:32] <= clint_wdata;
  end

  // Stage p1: read data captured at the AR handshake, interrupt compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_p1 <= 32'h0;
      mtip_p1  <= 1'b0;
    end else begin
      if (ar_hs) rdata_p1 <= rd_mux(clint_araddr[ADDR_W-1:0]);
      mtip_p1 <= (mtime >= mtimecmp);
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
    end
  end

  // Read channel next state.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: begin
        if (clint_arvalid) begin
`ifdef CLINT_RAND_DELAY_EN
          r_next = (lfsr[1:0] == 2'd0) ? R_RESP : R_WAIT;
`else
          r_next = R_RESP;
`endif
        end
      end
`ifdef CLINT_RAND_DELAY_EN
      R_WAIT: if (r_cnt == 2'd1) r_next = R_RESP;
`endif
      R_RESP: if (clint_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Write channel next state; AW and W are only taken together.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: begin
        if (w_hs) begin
`ifdef CLINT_RAND_DELAY_EN
          w_next = (lfsr[1:0] == 2'd0) ? W_RESP : W_WAIT;
`else
          w_next = W_RESP;
`endif
        end
      end
`ifdef CLINT_RAND_DELAY_EN
      W_WAIT: if (w_cnt == 2'd1) w_next = W_RESP;
`endif
      W_RESP: if (clint_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060240_clint.sv
// Directed testbench for ysyx_23060240_clint with TICK_DIV=1.
module tb_ysyx_23060240_clint;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        mtip;
  int          errors = 0;
  int          checks = 0;

  ysyx_23060240_clint #(.TICK_DIV(1), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .clint_araddr(araddr), .clint_arvalid(arvalid), .clint_arready(arready),
    .clint_rdata(rdata), .clint_rvalid(rvalid), .clint_rready(rready),
    .clint_awaddr(awaddr), .clint_awvalid(awvalid), .clint_awready(awready),
    .clint_wdata(wdata), .clint_wvalid(wvalid), .clint_wready(wready),
    .clint_bvalid(bvalid), .clint_bready(bready), .mtip(mtip)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Read: handshake on the next edge, returns data/valid seen after it.
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic rv);
    araddr = a; arvalid = 1'b1;
    step();
    arvalid = 1'b0; d = rdata; rv = rvalid; rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  // Write: handshake on the next edge, returns bvalid seen after it.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] dt, output logic bv);
    awaddr = a; wdata = dt; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; bv = bvalid; bready = 1'b1;
    step();
    bready = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d; logic rv;
    rst = 1'b1;
    araddr = 0; arvalid = 0; rready = 0; awaddr = 0; awvalid = 0; wdata = 0; wvalid = 0; bready = 0;
    step(); step();
    rst = 1'b0;
    checks++; if (mtip !== 1'b0) begin errors++; $display("FAIL reset_mtip: got %b want 0", mtip); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL reset_bvalid: got %b want 0", bvalid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL reset_arready: got %b want 1", arready); end
    checks++; if (awready !== 1'b0) begin errors++; $display("FAIL reset_awready: got %b want 0", awready); end
    step(); step(); step();
    araddr = 32'hBFF8; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL first_rvalid: got %b want 1", rvalid); end
    checks++; if (rdata !== 32'd3) begin errors++; $display("FAIL first_rdata: got %h want 3", rdata); end
    rready = 1'b1;
    step();
    rready = 1'b0;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL first_rvalid_clr: got %b want 0", rvalid); end
    bus_read(32'h4004, d, rv);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_hi: got %h want ffffffff", d); end
  endtask

  task automatic test_mtime_carry;
    logic [31:0] d; logic rv;
    awaddr = 32'hBFF8; wdata = 32'hFFFF_FFFE; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    step();
    bready = 1'b0;
    awaddr = 32'hBFFC; wdata = 32'h1; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; araddr = 32'hBFF8; arvalid = 1'b1;
    step();
    // lo held at FFFFFFFF on the hi-write edge (write beats the tick).
    arvalid = 1'b0; bready = 1'b0;
    checks++; if (rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL collide_lo: got %h want ffffffff", rdata); end
    rready = 1'b1;
    step();
    rready = 1'b0;
    bus_read(32'hBFFC, d, rv);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL carry_hi: got %h want 2", d); end
    bus_read(32'hBFF8, d, rv);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL carry_lo: got %h want 3", d); end
  endtask

  task automatic test_mtip;
    logic bv; logic [31:0] d; logic rv;
    bus_write(32'hBFFC, 32'h0, bv);
    bus_write(32'hBFF8, 32'h0, bv);
    bus_write(32'h4004, 32'h0, bv);
    bus_write(32'h4000, 32'd24, bv);
    checks++; if (mtip !== 1'b0) begin errors++; $display("FAIL mtip_early: got %b want 0", mtip); end
    for (int i = 0; i < 19; i++) step();
    checks++; if (mtip !== 1'b0) begin errors++; $display("FAIL mtip_before: got %b want 0", mtip); end
    step();
    checks++; if (mtip !== 1'b1) begin errors++; $display("FAIL mtip_rise: got %b want 1", mtip); end
    awaddr = 32'h4004; wdata = 32'hFFFF_FFFF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL cmp_bvalid: got %b want 1", bvalid); end
    checks++; if (mtip !== 1'b1) begin errors++; $display("FAIL mtip_hold: got %b want 1", mtip); end
    bready = 1'b1;
    step();
    bready = 1'b0;
    checks++; if (mtip !== 1'b0) begin errors++; $display("FAIL mtip_clear: got %b want 0", mtip); end
    bus_read(32'h4000, d, rv);
    checks++; if (d !== 32'd24) begin errors++; $display("FAIL cmp_lo_rd: got %h want 18", d); end
  endtask

  task automatic test_backpressure;
    logic [31:0] d; logic rv;
    araddr = 32'h4000; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (rvalid !== 1'b1 || rdata !== 32'd24 || arready !== 1'b0) begin
        errors++; $display("FAIL rd_hold%0d: got v=%b d=%h ar=%b want 1 18 0", i, rvalid, rdata, arready);
      end
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rd_release: got %b want 0", rvalid); end
    awaddr = 32'h4000; wdata = 32'd99; awvalid = 1'b1; wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (awready !== 1'b0 || bvalid !== 1'b0) begin
        errors++; $display("FAIL aw_alone%0d: got aw=%b b=%b want 0 0", i, awready, bvalid);
      end
    end
    wvalid = 1'b1;
    #1;
    checks++; if (awready !== 1'b1 || wready !== 1'b1) begin errors++; $display("FAIL aw_w_join: got %b%b want 11", awready, wready); end
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL join_bvalid: got %b want 1", bvalid); end
    bready = 1'b1;
    step();
    bready = 1'b0;
    bus_read(32'h4000, d, rv);
    checks++; if (d !== 32'd99) begin errors++; $display("FAIL join_data: got %h want 63", d); end
  endtask

  task automatic test_unmapped;
    logic [31:0] d; logic rv; logic bv;
    bus_read(32'h1234, d, rv);
    checks++; if (d !== 32'h0 || rv !== 1'b1) begin errors++; $display("FAIL unmapped_rd: got %h v=%b want 0 1", d, rv); end
    bus_write(32'h1234, 32'hDEAD_BEEF, bv);
    checks++; if (bv !== 1'b1) begin errors++; $display("FAIL unmapped_bvalid: got %b want 1", bv); end
    bus_read(32'h4000, d, rv);
    checks++; if (d !== 32'd99) begin errors++; $display("FAIL unmapped_cmp_lo: got %h want 63", d); end
    bus_read(32'h0200_4004, d, rv);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL upper_addr_ign: got %h want ffffffff", d); end
  endtask

  task automatic test_back_to_back_reset;
    logic [31:0] d; logic rv;
    araddr = 32'h4000; arvalid = 1'b1;
    awaddr = 32'h4000; wdata = 32'd5; awvalid = 1'b1; wvalid = 1'b1;
    step();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    checks++; if (rvalid !== 1'b1 || bvalid !== 1'b1) begin errors++; $display("FAIL dual_valid: got r=%b b=%b want 1 1", rvalid, bvalid); end
    checks++; if (rdata !== 32'd99) begin errors++; $display("FAIL rd_prewrite: got %h want 63", rdata); end
    rst = 1'b1;
    step();
    checks++; if (rvalid !== 1'b0 || bvalid !== 1'b0) begin errors++; $display("FAIL rst_valids: got r=%b b=%b want 0 0", rvalid, bvalid); end
    checks++; if (mtip !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL rst_out: got mtip=%b d=%h want 0 0", mtip, rdata); end
    rst = 1'b0;
    bus_read(32'hBFF8, d, rv);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mtime: got %h want 0", d); end
    bus_read(32'h4000, d, rv);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_cmp_lo: got %h want ffffffff", d); end
    bus_read(32'h4004, d, rv);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_cmp_hi: got %h want ffffffff", d); end
  endtask

  initial begin
    test_reset();
    test_mtime_carry();
    test_mtip();
    test_backpressure();
    test_unmapped();
    test_back_to_back_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
